// File: rtl/ram_arbiter.sv
// ram_arbiter: zero-fills the attached RAM after reset, then round-robin arbitrates
// two requesters onto its single read/write port pair with read data routed back.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  init_done,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    typedef enum logic {INIT, RUN} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_init_done;
    logic                  r_rr_ptr;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic                  w_last;
    logic                  w_run;

    assign w_last = &r_init_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= INIT;
        else        r_state <= w_next;
    end

    always_comb w_next = (r_state == INIT && w_last) ? RUN : r_state;

    // rr_ptr names the requester that wins the next contention
    always_comb begin
        w_run          = r_state == RUN;
        gnt0           = w_run & req0 & (~req1 | ~r_rr_ptr);
        gnt1           = w_run & req1 & (~req0 | r_rr_ptr);
        ram_we         = rst_n & (~w_run | (gnt0 & we0) | (gnt1 & we1));
        ram_write_addr = ~w_run ? r_init_cnt : gnt1 ? addr1 : addr0;
        ram_data       = ~w_run ? '0 : gnt1 ? wdata1 : wdata0;
        ram_read_addr  = gnt1 ? addr1 : addr0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
        end else begin
            r_init_cnt  <= (r_state == INIT) ? r_init_cnt + 1'b1 : r_init_cnt;
            r_init_done <= r_init_done | (r_state == INIT && w_last);
            r_rr_ptr    <= gnt0 ? 1'b1 : gnt1 ? 1'b0 : r_rr_ptr;
            r_rvalid0   <= gnt0 & ~we0;
            r_rvalid1   <= gnt1 & ~we1;
        end
    end

    assign init_done = r_init_done;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = ram_q;
    assign rdata1    = ram_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random and directed traffic against a memory/round-robin reference
// model, with a queue-based monitor checking returned read data and its timing.
module tb_ram_arbiter;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int          cyc;
        int          who;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req[2];
    logic          we[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wdata[2];
    logic          gnt0, gnt1, rvalid0, rvalid1, init_done, ram_we;
    logic [DW-1:0] rdata0, rdata1, ram_data, ram_q;
    logic [AW-1:0] ram_read_addr, ram_write_addr;
    logic [DW-1:0] mem[DEPTH];

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            last = 1;
    bit            got[2];
    logic [DW-1:0] ref_mem[DEPTH];
    exp_t          exp_q[$];

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .init_done(init_done),
        .ram_data(ram_data), .ram_read_addr(ram_read_addr),
        .ram_write_addr(ram_write_addr), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // simple dual-port RAM with registered read, contents survive reset
    always @(posedge clk) begin
        if (ram_we) mem[ram_write_addr] <= ram_data;
        ram_q <= mem[ram_read_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rvalid0 || rvalid1) begin
            if (exp_q.size() == 0) chk("rvalid_spurious", {30'd0, rvalid1, rvalid0}, 0);
            else begin
                e = exp_q.pop_front();
                chk("rvalid_cycle", cyc, e.cyc);
                chk("rvalid_who", {30'd0, rvalid1, rvalid0}, e.who ? 2 : 1);
                chk("rdata", e.who ? rdata1 : rdata0, e.d);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("rvalid_missing", {30'd0, rvalid1, rvalid0}, e.who ? 2 : 1);
        end
    end

    task automatic step();
        bit e0, e1;
        int w;
        @(negedge clk);
        e0 = req[0] && (!req[1] || last == 1);
        e1 = req[1] && (!req[0] || last == 0);
        chk("init_done", init_done, 1);
        chk("gnt0", gnt0, e0);
        chk("gnt1", gnt1, e1);
        got[0] = e0;
        got[1] = e1;
        if (e0 || e1) begin
            w = e1 ? 1 : 0;
            last = w;
            if (we[w]) begin
                chk("wr_we", ram_we, 1);
                chk("wr_addr", ram_write_addr, addr[w]);
                chk("wr_data", ram_data, wdata[w]);
                ref_mem[addr[w]] = wdata[w];
            end else begin
                chk("rd_we", ram_we, 0);
                chk("rd_addr", ram_read_addr, addr[w]);
                exp_q.push_back('{cyc + 1, w, ref_mem[addr[w]]});
            end
        end else chk("idle_we", ram_we, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic init_seq();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("init_we", ram_we, 1);
            chk("init_waddr", ram_write_addr, i);
            chk("init_wdata", ram_data, 0);
            chk("init_done_low", init_done, 0);
            chk("init_gnt0", gnt0, 0);
            @(posedge clk);
            #1;
        end
        foreach (ref_mem[i]) ref_mem[i] = '0;
        last = 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_we", ram_we, 0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_gnt0", gnt0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        init_seq();
    endtask

    initial begin
        foreach (mem[i]) mem[i] = DW'($urandom);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 3'd5; wdata[0] = '0;
        req[1] = 1'b0; we[1] = 1'b0; addr[1] = '0;   wdata[1] = '0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            addr[0] = AW'(i);
            step();
        end
        we[0] = 1'b1; addr[0] = 3'd3; wdata[0] = 8'hA5; step();
        we[0] = 1'b0; step();
        addr[0] = 3'd1; wdata[0] = 8'h11; we[0] = 1'b1; step();
        addr[0] = 3'd2; wdata[0] = 8'h22; step();
        we[0] = 1'b0; addr[0] = 3'd1; req[1] = 1'b1; addr[1] = 3'd2;
        for (int i = 0; i < 4; i++) step();
        req[0] = 1'b0; addr[1] = 3'd3;
        for (int i = 0; i < 3; i++) step();
        req[1] = 1'b0; step();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++)
                if (!req[i] || got[i]) begin
                    req[i]   = 1'($urandom_range(1));
                    we[i]    = 1'($urandom_range(1));
                    addr[i]  = AW'($urandom);
                    wdata[i] = DW'($urandom);
                end
            step();
        end
        req[1] = 1'b0;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 3'd3; wdata[0] = 8'h5A; step();
        we[0] = 1'b0; step();
        do_reset();
        step();
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 3'd4; addr[0] = 3'd1; step();
        req[0] = 1'b0; req[1] = 1'b0; step();
        step();
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
